timer_alarm: RTL and testbench

//  Compare/alarm stage downstream of the 64-bit timer core. Consumes the free-running

---
 rtl/timer_alarm.sv | 110 +++++++++++
 tb/tb_timer_alarm.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_alarm.sv
// Compare/alarm stage beside the 64-bit timer: sticky irq when timer_value reaches cmp_value,
// one-shot or periodic auto-reload. Optional fire counter enabled by TIMER_ALARM_CNT_EN.
module timer_alarm #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CNT_W-1:0]  timer_value,
    input  logic              wr_en,
    input  logic [1:0]        wr_addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              arm,
    input  logic              disarm,
    input  logic              periodic,
    input  logic              irq_ack,
    output logic              irq,
    output logic              overrun,
    output logic              armed,
    output logic [CNT_W-1:0]  cmp_value,
    output logic [15:0]       fire_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FIRED = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] cmp_lo_stage;
    logic [DATA_W-1:0] period;
    logic              match;
    logic              fire;
    logic              reload;
    logic              commit;

    assign match  = (timer_value >= cmp_value);
    assign commit = wr_en && (wr_addr == 2'd1);
    assign armed  = (state == ARMED);

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        fire       = 1'b0;
        reload     = 1'b0;
        if (disarm) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (arm) state_next = ARMED;
                ARMED: begin
                    if (match) begin
                        fire = 1'b1;
                        if (periodic && (period != '0)) reload = 1'b1;
                        else                            state_next = FIRED;
                    end
                end
                FIRED:   if (arm) state_next = ARMED;
                default: state_next = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cmp_lo_stage <= '0;
            period       <= '0;
            cmp_value    <= '0;
        end else begin
            state <= state_next;
            if (wr_en && (wr_addr == 2'd0)) cmp_lo_stage <= wdata;
            if (wr_en && (wr_addr == 2'd2)) period       <= wdata;
            // A committed software write overrides a same-cycle periodic reload.
            if (commit)      cmp_value <= {wdata, cmp_lo_stage};
            else if (reload) cmp_value <= cmp_value + {{(CNT_W-DATA_W){1'b0}}, period};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq     <= 1'b0;
            overrun <= 1'b0;
        end else if (fire) begin
            irq <= 1'b1;
            if (irq) overrun <= 1'b1;
        end else if (irq_ack) begin
            irq     <= 1'b0;
            overrun <= 1'b0;
        end
    end

`ifdef TIMER_ALARM_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_cnt <= '0;
        end else if (wr_en && (wr_addr == 2'd3)) begin
            fire_cnt <= '0;
        end else if (fire && (fire_cnt != 16'hFFFF)) begin
            fire_cnt <= fire_cnt + 16'd1;
        end
    end
`else
    assign fire_cnt = '0;
`endif

endmodule

// File: tb/tb_timer_alarm.sv
// Directed bench for timer_alarm: write staging, one-shot, periodic reload, overrun/ack,
// arm/disarm priority, async reset and (when enabled) the saturating fire counter.
module tb_timer_alarm;

    logic        clk;
    logic        rst;
    logic [63:0] timer_value;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wdata;
    logic        arm;
    logic        disarm;
    logic        periodic;
    logic        irq_ack;
    logic        irq;
    logic        overrun;
    logic        armed;
    logic [63:0] cmp_value;
    logic [15:0] fire_cnt;

    int tests = 0;
    int fails = 0;

    timer_alarm #(.DATA_W(32), .CNT_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .timer_value(timer_value),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wdata      (wdata),
        .arm        (arm),
        .disarm     (disarm),
        .periodic   (periodic),
        .irq_ack    (irq_ack),
        .irq        (irq),
        .overrun    (overrun),
        .armed      (armed),
        .cmp_value  (cmp_value),
        .fire_cnt   (fire_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [1:0] addr, input logic [31:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wdata   = data;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic pulse_disarm();
        disarm = 1'b1;
        step();
        disarm = 1'b0;
    endtask

    task automatic pulse_ack();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    initial begin
        int first_irq;
        int nf;
        int ft[3];
        logic pend;

        rst = 1'b1; timer_value = '0; wr_en = 1'b0; wr_addr = '0; wdata = '0;
        arm = 1'b0; disarm = 1'b0; periodic = 1'b0; irq_ack = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        check("rst_irq",      64'(irq),      64'd0);
        check("rst_overrun",  64'(overrun),  64'd0);
        check("rst_armed",    64'(armed),    64'd0);
        check("rst_cmp",      cmp_value,     64'd0);
        check("rst_fire_cnt", 64'(fire_cnt), 64'd0);

        // Staged 64-bit compare: LO alone must not change the active value
        write(2'd0, 32'h1);
        check("lo_staged_only", cmp_value, 64'd0);
        write(2'd1, 32'h2);
        check("hi_commit", cmp_value, 64'h0000_0002_0000_0001);
        timer_value = 64'h1_FFFF_FFFF;
        pulse_arm();
        step(); step();
        check("below_no_fire", 64'(irq),   64'd0);
        check("below_armed",   64'(armed), 64'd1);
        timer_value = 64'h2_0000_0001;
        step();
        check("equal_fires",   64'(irq),   64'd1);
        check("oneshot_fired", 64'(armed), 64'd0);
        pulse_ack();
        check("ack_clears", 64'(irq), 64'd0);

        // One-shot at 100, timer sweeps 0..200
        timer_value = '0;
        write(2'd0, 32'd100);
        write(2'd1, 32'd0);
        pulse_arm();
        first_irq = -1;
        for (int t = 0; t <= 200; t++) begin
            timer_value = 64'(t);
            step();
            if (irq && first_irq < 0) first_irq = t;
        end
        check("oneshot_latency", 64'(first_irq), 64'd100);
        check("oneshot_state",   64'(armed),     64'd0);
        check("oneshot_no_more", 64'(overrun),   64'd0);
        pulse_ack();

        // Periodic: cmp=50, period=20, fires at 50/70/90
        timer_value = '0;
        periodic = 1'b1;
        write(2'd2, 32'd20);
        write(2'd0, 32'd50);
        write(2'd1, 32'd0);
        pulse_arm();
        nf = 0; pend = 1'b0;
        ft[0] = -1; ft[1] = -1; ft[2] = -1;
        for (int t = 0; t <= 100; t++) begin
            irq_ack = pend;
            pend = 1'b0;
            timer_value = 64'(t);
            step();
            if (irq) begin
                if (nf < 3) ft[nf] = t;
                nf++;
                pend = 1'b1;
            end
        end
        irq_ack = pend;
        step();
        irq_ack = 1'b0;
        check("per_count",   64'(nf),    64'd3);
        check("per_fire0",   64'(ft[0]), 64'd50);
        check("per_fire1",   64'(ft[1]), 64'd70);
        check("per_fire2",   64'(ft[2]), 64'd90);
        check("per_cmp",     cmp_value,  64'd110);
        check("per_armed",   64'(armed), 64'd1);
        check("per_no_ovr",  64'(overrun), 64'd0);

        // Overrun: timer far past compare fires every cycle
        timer_value = 64'd200;
        step();
        check("ovr_first_irq", 64'(irq),     64'd1);
        check("ovr_first_ovr", 64'(overrun), 64'd0);
        step();
        check("ovr_set",       64'(overrun), 64'd1);
        check("ovr_cmp",       cmp_value,    64'd150);
        pulse_disarm();
        check("disarm_idle",   64'(armed),   64'd0);
        check("disarm_keeps_irq", 64'(irq),  64'd1);
        check("disarm_keeps_ovr", 64'(overrun), 64'd1);
        pulse_ack();
        check("ack_irq", 64'(irq),     64'd0);
        check("ack_ovr", 64'(overrun), 64'd0);
        pulse_arm();
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        check("ack_vs_fire_irq", 64'(irq),     64'd1);
        check("ack_vs_fire_ovr", 64'(overrun), 64'd0);
        pulse_disarm();
        pulse_ack();

        // Commit write in the same cycle as a reload: write wins
        timer_value = 64'd1000;
        write(2'd0, 32'h500);
        pulse_arm();
        wr_en = 1'b1; wr_addr = 2'd1; wdata = 32'd0;
        step();
        wr_en = 1'b0;
        check("commit_wins_cmp", cmp_value, 64'h500);
        check("commit_wins_irq", 64'(irq),  64'd1);
        step();
        check("after_commit_no_ovr", 64'(overrun), 64'd0);
        pulse_disarm();
        pulse_ack();

        // Periodic with period 0 behaves as one-shot
        write(2'd2, 32'd0);
        write(2'd0, 32'h10);
        write(2'd1, 32'd0);
        pulse_arm();
        step();
        check("p0_irq",   64'(irq),   64'd1);
        check("p0_fired", 64'(armed), 64'd0);
        check("p0_cmp",   cmp_value,  64'h10);

        // arm+disarm together: disarm wins
        timer_value = '0;
        arm = 1'b1; disarm = 1'b1;
        step();
        arm = 1'b0; disarm = 1'b0;
        check("arm_disarm", 64'(armed), 64'd0);
        pulse_arm();
        check("rearm",        64'(armed), 64'd1);
        check("rearm_irq_on", 64'(irq),   64'd1);

        // Async reset while ARMED with irq set
        #2;
        rst = 1'b1;
        #1;
        check("arst_irq",   64'(irq),     64'd0);
        check("arst_ovr",   64'(overrun), 64'd0);
        check("arst_armed", 64'(armed),   64'd0);
        check("arst_cmp",   cmp_value,    64'd0);
        check("arst_cnt",   64'(fire_cnt), 64'd0);
        step();
        rst = 1'b0;
        step();

        // Fire counter: cmp=0, period=1, timer=2 gives exactly three fires
        write(2'd2, 32'd1);
        periodic = 1'b1;
        timer_value = 64'd2;
        pulse_arm();
        step(); step(); step(); step();
        check("cnt_cmp_after3", cmp_value, 64'd3);
`ifdef TIMER_ALARM_CNT_EN
        check("cnt_three", 64'(fire_cnt), 64'd3);
        write(2'd3, 32'd0);
        check("cnt_clear", 64'(fire_cnt), 64'd0);
        timer_value = 64'hFFFF_FFFF;
        for (int i = 0; i < 65540; i++) step();
        check("cnt_saturate", 64'(fire_cnt), 64'hFFFF);
        write(2'd3, 32'd0);
        check("cnt_clear_wins", 64'(fire_cnt), 64'd0);
`else
        check("cnt_disabled", 64'(fire_cnt), 64'd0);
`endif
        pulse_disarm();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
